// File: rtl/apb_slave_regfile_pkg.sv
// apb_slv_pkg: shared widths, FSM state type and address range helper for the APB register file
package apb_slv_pkg;
  localparam int APB_AWIDTH = 8;
  localparam int APB_DWIDTH = 32;
  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_slv_state_t;
  function automatic logic in_range(input logic [31:0] a, input int unsigned d);
    return a < d;
  endfunction
endpackage

// File: rtl/apb_slave_regfile_mem.sv
// apb_slv_mem: DEPTH x DWIDTH word array, sync write and clear, combinational read
module apb_slv_mem #(
  parameter int DEPTH  = 64,
  parameter int DWIDTH = 32,
  parameter int IW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [IW-1:0]     raddr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB slave register file with programmable wait states.
// Define APB_SLVERR_EN to add the p_slverr output for out-of-range accesses.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int AWIDTH      = APB_AWIDTH,
  parameter int DWIDTH      = APB_DWIDTH,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_sel,
  input  logic              p_en,
  input  logic              p_write,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              p_ready
`ifdef APB_SLVERR_EN
  , output logic            p_slverr
`endif
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  apb_slv_state_t    state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [AWIDTH-1:0] addr_q, cur_addr;
  logic [DWIDTH-1:0] wdata_q, mem_rdata, rdata_n;
  logic              write_q, cur_write, capture, ok, ready_n, slverr_n, we;
  assign capture = state == IDLE && p_sel && !p_en;
  // With zero wait states READY is entered straight from IDLE, before the latches hold the request
  assign cur_addr  = state == IDLE ? addr : addr_q;
  assign cur_write = state == IDLE ? p_write : write_q;
  assign ok        = in_range(32'(cur_addr), DEPTH);
  assign we        = state == READY && p_sel && p_en && write_q && in_range(32'(addr_q), DEPTH);
  apb_slv_mem #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .IW(IW)) u_mem (
    .clk(clk), .rst(rst), .we(we),
    .waddr(addr_q[IW-1:0]), .raddr(cur_addr[IW-1:0]),
    .wdata(wdata_q), .rdata(mem_rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p_ready <= 1'b0;
      rdata   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef APB_SLVERR_EN
      p_slverr <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      p_ready <= ready_n;
      rdata   <= rdata_n;
      if (capture) begin
        addr_q  <= addr;
        write_q <= p_write;
        wdata_q <= wdata;
      end
`ifdef APB_SLVERR_EN
      p_slverr <= slverr_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:  if (capture) begin
               state_n = WAIT_CYCLES == 0 ? READY : WAIT;
               cnt_n   = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
             end
      WAIT:  begin
               state_n = !p_sel ? IDLE : cnt == 0 ? READY : WAIT;
               cnt_n   = p_sel && cnt != 0 ? cnt - 4'd1 : cnt;
             end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ready_n  = state_n == READY;
    rdata_n  = ready_n && !cur_write && ok ? mem_rdata : '0;
    slverr_n = ready_n && !ok;
  end
`ifndef APB_SLVERR_EN
  logic unused_slverr;
  assign unused_slverr = slverr_n;
`endif
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench driving a 2-wait and a 0-wait instance over a shared bus
module tb_apb_slave_regfile;
  logic        clk = 1'b0, rst = 1'b1;
  logic        p_sel2 = 1'b0, p_sel0 = 1'b0, p_en = 1'b0, p_write = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, rdata2, rdata0;
  logic        p_ready2, p_ready0, slverr2, slverr0;
  logic [31:0] ref2 [64], ref0 [64];
  logic [31:0] exp_q [$];
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .p_sel(p_sel2), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .p_ready(p_ready2)
`ifdef APB_SLVERR_EN
    , .p_slverr(slverr2)
`endif
  );
  apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .p_sel(p_sel0), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .p_ready(p_ready0)
`ifdef APB_SLVERR_EN
    , .p_slverr(slverr0)
`endif
  );
`ifndef APB_SLVERR_EN
  assign slverr2 = 1'b0;
  assign slverr0 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      ref2[i] = '0;
      ref0[i] = '0;
    end
  endtask

  // Called just after a rising edge; returns just after the completion edge
  task automatic xfer(input bit z, input bit w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    logic [31:0] exp;
    p_sel2 = !z; p_sel0 = z; p_en = 1'b0; p_write = w; addr = a; wdata = d;
    exp_q.push_back(w || a >= 64 ? 32'h0 : z ? ref0[a] : ref2[a]);
    @(posedge clk) #1;
    p_en = 1'b1; addr = ~a; wdata = ~d;
    do begin
      @(negedge clk);
      n++;
    end while (!(z ? p_ready0 : p_ready2) && n < 20);
    check("latency", 32'(n), z ? 32'd1 : 32'd3);
    exp = exp_q.pop_front();
    check(w ? "wr_rdata" : "rd_rdata", z ? rdata0 : rdata2, exp);
`ifdef APB_SLVERR_EN
    check("slverr", {31'b0, z ? slverr0 : slverr2}, {31'b0, a >= 64});
`endif
    @(posedge clk) #1;
    check("ready_pulse", {31'b0, z ? p_ready0 : p_ready2}, 32'd0);
    if (w && a < 64) begin
      if (z) ref0[a] = d;
      else ref2[a] = d;
    end
  endtask

  task automatic idle(input int n);
    p_sel2 = 1'b0; p_sel0 = 1'b0; p_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, p_ready2}, 32'd0);
    check("rst_rdata", rdata2, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    xfer(0, 0, 8'h05, 32'h0);
    xfer(0, 1, 8'h10, 32'hDEAD_BEEF);
    xfer(0, 0, 8'h10, 32'h0);
    idle(2);
    xfer(1, 1, 8'h3F, 32'h1234_5678);
    xfer(1, 0, 8'h3F, 32'h0);
    idle(1);
    xfer(0, 1, 8'h00, 32'hCAFE_F00D);
    xfer(0, 1, 8'h40, 32'hFFFF_FFFF);
    xfer(0, 0, 8'h40, 32'h0);
    xfer(0, 0, 8'h00, 32'h0);
    xfer(0, 1, 8'h02, 32'h1357_2468);
    idle(1);
    p_sel2 = 1'b1; p_en = 1'b0; p_write = 1'b1; addr = 8'h02; wdata = 32'hA5A5_A5A5;
    @(posedge clk) #1;
    p_en = 1'b1;
    @(posedge clk) #1;
    p_sel2 = 1'b0; p_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_ready", {31'b0, p_ready2}, 32'd0);
    end
    @(posedge clk) #1;
    xfer(0, 0, 8'h02, 32'h0);
    xfer(0, 1, 8'h07, 32'h1111_1111);
    xfer(0, 0, 8'h07, 32'h0);
    idle(1);
    p_sel2 = 1'b1; p_en = 1'b0; p_write = 1'b1; addr = 8'h07; wdata = 32'h2222_2222;
    @(posedge clk) #1;
    p_en = 1'b1; rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0; p_sel2 = 1'b0; p_en = 1'b0;
    clear_model();
    @(negedge clk);
    check("midrst_ready", {31'b0, p_ready2}, 32'd0);
    @(posedge clk) #1;
    xfer(0, 0, 8'h07, 32'h0);
    xfer(1, 0, 8'h3F, 32'h0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 70));
      xfer(0, 1, a, $urandom);
      xfer(0, 0, a, 32'h0);
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
